// File: rtl/vx_mask_pkg.sv
// Shared types and width helpers for the streaming index-to-mask decoder.
package vx_mask_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } accState_e;

    function automatic int log2Up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int countWidth(input int ln);
        return ln + 1;
    endfunction

endpackage

// File: rtl/VX_popcount.sv
// Combinational population count of an N-bit vector into an M-bit result.
module VX_popcount #(
    parameter int N = 8,
    parameter int M = $clog2(N + 1)
) (
    input  logic [N-1:0] data_in,
    output logic [M-1:0] data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            data_out = data_out + M'(data_in[i]);
        end
    end

endmodule

// File: rtl/vx_index_onehot.sv
// Combinational binary-index to one-hot decoder; indices >= N decode to zero and flag range_err.
module vx_index_onehot
    import vx_mask_pkg::*;
#(
    parameter int N       = 8,
    parameter bit REVERSE = 1'b0,
    parameter int LN      = log2Up(N)
) (
    input  logic [LN-1:0] index,
    output logic [N-1:0]  onehot,
    output logic          range_err
);

    always_comb begin
        onehot    = '0;
        range_err = (int'(index) >= N);
        for (int i = 0; i < N; i++) begin
            if (int'(index) == i) begin
                onehot[REVERSE ? (N - 1 - i) : i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_mask_decoder.sv
// Streaming index-to-mask decoder: OR-accumulates one-hot indices per message and hands the mask downstream.
// Optional duplicate-index reporting (out_dup) is enabled by defining VX_MASK_DECODER_DUP_CHK_EN.
module vx_mask_decoder
    import vx_mask_pkg::*;
#(
    parameter int N       = 8,
    parameter bit REVERSE = 1'b0,
    parameter int LN      = log2Up(N)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [LN-1:0]             in_index,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [N-1:0]              out_mask,
    output logic [countWidth(LN)-1:0] out_count,
    output logic                      out_err,
`ifdef VX_MASK_DECODER_DUP_CHK_EN
    output logic                      out_dup,
`endif
    input  logic                      out_ready
);

    localparam int CW = countWidth(LN);

    accState_e state_q, state_d;

    logic [N-1:0]  accMask_q, accMask_d;
    logic          accErr_q, accErr_d;
    logic          outValid_q, outValid_d;
    logic [N-1:0]  outMask_q, outMask_d;
    logic [CW-1:0] outCount_q, outCount_d;
    logic          outErr_q, outErr_d;

    logic          accept;
    logic [N-1:0]  onehot;
    logic          rangeErr;
    logic [N-1:0]  baseMask;
    logic [N-1:0]  nextMask;
    logic          nextErr;
    logic [CW-1:0] nextCount;

    vx_index_onehot #(
        .N       (N),
        .REVERSE (REVERSE),
        .LN      (LN)
    ) u_onehot (
        .index     (in_index),
        .onehot    (onehot),
        .range_err (rangeErr)
    );

    // The count is taken from the mask about to be registered, never from the live inputs.
    VX_popcount #(
        .N (N),
        .M (CW)
    ) u_popcount (
        .data_in  (nextMask),
        .data_out (nextCount)
    );

    assign in_ready = !outValid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign baseMask = (state_q == ACCUM) ? accMask_q : '0;
    assign nextMask = baseMask | onehot;
    assign nextErr  = ((state_q == ACCUM) & accErr_q) | rangeErr;

`ifdef VX_MASK_DECODER_DUP_CHK_EN
    logic accDup_q, accDup_d;
    logic outDup_q, outDup_d;
    logic nextDup;

    assign nextDup = ((state_q == ACCUM) & accDup_q) | (|(baseMask & onehot));
    assign out_dup = outDup_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? EMPTY : ACCUM;
        end
    end

    // A last beat closes the message: its mask goes to the output register and the accumulator restarts.
    always_comb begin
        accMask_d  = accMask_q;
        accErr_d   = accErr_q;
        outValid_d = outValid_q;
        outMask_d  = outMask_q;
        outCount_d = outCount_q;
        outErr_d   = outErr_q;
`ifdef VX_MASK_DECODER_DUP_CHK_EN
        accDup_d   = accDup_q;
        outDup_d   = outDup_q;
`endif
        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
        if (accept) begin
            if (in_last) begin
                accMask_d  = '0;
                accErr_d   = 1'b0;
                outValid_d = 1'b1;
                outMask_d  = nextMask;
                outCount_d = nextCount;
                outErr_d   = nextErr;
`ifdef VX_MASK_DECODER_DUP_CHK_EN
                accDup_d   = 1'b0;
                outDup_d   = nextDup;
`endif
            end else begin
                accMask_d  = nextMask;
                accErr_d   = nextErr;
`ifdef VX_MASK_DECODER_DUP_CHK_EN
                accDup_d   = nextDup;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accMask_q  <= '0;
            accErr_q   <= 1'b0;
            outValid_q <= 1'b0;
            outMask_q  <= '0;
            outCount_q <= '0;
            outErr_q   <= 1'b0;
`ifdef VX_MASK_DECODER_DUP_CHK_EN
            accDup_q   <= 1'b0;
            outDup_q   <= 1'b0;
`endif
        end else begin
            accMask_q  <= accMask_d;
            accErr_q   <= accErr_d;
            outValid_q <= outValid_d;
            outMask_q  <= outMask_d;
            outCount_q <= outCount_d;
            outErr_q   <= outErr_d;
`ifdef VX_MASK_DECODER_DUP_CHK_EN
            accDup_q   <= accDup_d;
            outDup_q   <= outDup_d;
`endif
        end
    end

    assign out_valid = outValid_q;
    assign out_mask  = outMask_q;
    assign out_count = outCount_q;
    assign out_err   = outErr_q;

endmodule

// File: doc/vx_mask_decoder.md
# vx_mask_decoder

- Streaming index-to-mask decoder, the producer-side counterpart of the priority encoder.
- Accepts a message of binary indices, one per beat, over a valid/ready handshake.
- Decodes each index to one-hot and OR-accumulates the bits into an N-bit mask.
- On the last beat, presents the registered mask and its population count to a downstream consumer that drains it bit by bit.

## Interface
Parameters:
- N, 8, mask width (N >= 2)
- REVERSE, 0, 1: index i maps to bit N-1-i; 0: index i maps to bit i
- LN, LOG2UP(N), index width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  index beat valid
- in_index  in  LN  binary index
- in_last  in  1  final beat of message
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_valid  out  1  mask valid
- out_mask  out  N  accumulated mask
- out_count  out  LN+1  popcount of out_mask
- out_err  out  1  at least one out-of-range index (>= N) in message
- out_ready  in  1  consumer takes mask when out_valid & out_ready

## Operation
- Accumulator FSM has two states.
  - EMPTY: acc_mask = 0, no beat of the current message taken yet.
  - ACCUM: at least one non-last beat taken.
- EMPTY -> ACCUM on an accepted non-last beat.
- ACCUM -> EMPTY, or EMPTY -> EMPTY, on an accepted last beat.
- Each accepted beat ORs decode(in_index) into the running mask and error flag.
- A last beat copies (acc_mask | decode(in_index)) into the output register and sets out_valid. It also clears acc_mask and acc_err in the same edge.
- Out-of-range index:
  - decodes to all-zero;
  - sets the error flag for the message;
  - the beat is still consumed.
- Duplicate index within a message: the bit is set once, and out_count does not double-count it.
- `in_ready = !out_valid | out_ready` for every beat, last or not. It has no combinational dependence on in_valid.
- Output register: out_valid clears on out_valid & out_ready, unless a last beat is accepted in the same cycle. In that case the new mask loads and out_valid stays 1.
- out_mask, out_count and out_err are stable while out_valid & !out_ready.
- An empty message is impossible: a lone last beat yields a 1-bit mask, or a 0 mask with out_err = 1 if its index is out of range.

## Timing
- Reset values: state EMPTY, acc_mask 0, acc_err 0, out_valid 0, out_mask 0, out_count 0, out_err 0. in_ready is then 1.
- Latency: last beat accepted at edge k gives out_valid = 1 after edge k. The mask is visible in cycle k+1.
- Throughput: one beat per cycle. Back-to-back single-beat messages sustain one mask per cycle while out_ready = 1.
- Backpressure: out_valid & !out_ready deasserts in_ready. Accumulation pauses and no beat is dropped.
- reset_n low mid-message: the message is discarded immediately, asynchronously, and all outputs take their reset values. The first beat after release starts a new message.
- out_count is computed from the next-mask value and registered alongside out_mask. It is never combinational from inputs.

## Configuration
- VX_MASK_DECODER_DUP_CHK_EN defined: adds output port out_dup (1 bit, reset 0, registered with out_mask).
  - out_dup is set when any accepted in-range index hits a bit already set in acc_mask, or already set earlier in the same message.
  - An internal acc_dup flag is cleared on message end.
- Undefined: no out_dup port and no duplicate-detection logic.
- Mask, count and error behaviour are identical in both builds.

## Structure
- Shared package vx_mask_pkg holds:
  - the state enum typedef (EMPTY, ACCUM);
  - a function computing the count width (LN+1).
- Natural sub-module: vx_index_onehot, a combinational index-to-one-hot decoder with parameters N and REVERSE. Outputs are onehot[N-1:0] and range_err.
- out_count uses the existing VX_popcount block.

## Test plan
- Reset, then message of indices 3, 5, 1 (last), N=8 -> out_valid one cycle after the last beat, out_mask = 8'b0010_1010, out_count = 2'd3 (4'd3), out_err = 0.
- REVERSE=1, single last beat with index 0 -> out_mask = 8'b1000_0000, out_count = 1.
- N=6 (LN=3), message 2, 7 (last) -> out_mask = 6'b000100, out_count = 1, out_err = 1.
- Indices 4, 4 (last) -> out_mask = 8'h10, out_count = 1; out_dup = 1 only when VX_MASK_DECODER_DUP_CHK_EN is defined.
- out_ready held 0 for 3 cycles after the first mask while in_valid stays 1:
  - in_ready stays 0 and the mask stays stable;
  - after out_ready rises, the next message accumulates correctly with no lost beats.
- reset_n pulsed low after beats 0, 1 of an unfinished message, then single last beat 6 -> out_mask = 8'h40, so no stale bits survive.
